// File: rtl/store_narrow_rmw_pkg.sv
// Shared encodings for the narrowing store path: access sizes, FSM states
// and the alignment legality check used when a store is accepted.
package store_narrow_rmw_pkg;

  // Access size as carried on st_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Store sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WRITE    = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERR_DONE = 3'd4
  } state_e;

  // A store is rejected without touching memory when it is misaligned
  // for its size or uses the reserved size code.
  function automatic logic is_bad_access(input size_e size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops the low byte/halfword of the store data
// into the addressed lane of the previously read word and reports whether
// the register value survives narrowing to the access size.
module store_lane_merge
  import store_narrow_rmw_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        is_signed,
  output logic [31:0] merged,
  output logic        ovf
);

  logic [1:0]  byte_idx;
  logic        half_idx;
  logic [4:0]  shamt;
  logic [31:0] mask;
  logic [31:0] ins;

  // Physical lane position: big-endian puts byte 0 in the top bits.
  assign byte_idx = BIG_ENDIAN ? (2'd3 - lane) : lane;
  assign half_idx = BIG_ENDIAN ? ~lane[1] : lane[1];

  // Build the lane mask/insert value and the overflow flag per size.
  always_comb begin
    shamt = '0;
    mask  = '0;
    ins   = '0;
    ovf   = 1'b0;
    case (size)
      SZ_BYTE: begin
        shamt = {byte_idx, 3'b000};
        mask  = 32'h0000_00FF << shamt;
        ins   = {24'h00_0000, data[7:0]} << shamt;
        ovf   = is_signed ? (data[31:8] != {24{data[7]}}) : (data[31:8] != '0);
      end
      SZ_HALF: begin
        shamt = {half_idx, 4'b0000};
        mask  = 32'h0000_FFFF << shamt;
        ins   = {16'h0000, data[15:0]} << shamt;
        ovf   = is_signed ? (data[31:16] != {16{data[15]}}) : (data[31:16] != '0);
      end
      SZ_WORD: begin
        mask = '1;
        ins  = data;
      end
      default: begin
        mask = '0;
        ins  = '0;
      end
    endcase
    merged = (old_word & ~mask) | ins;
  end

endmodule

// File: rtl/store_narrow_rmw.sv
// Narrowing store unit: accepts one store at a time, writes words directly
// and performs read-modify-write for bytes/halfwords on a memory port with
// no byte enables. Misaligned/illegal stores and ack timeouts finish with
// st_err; narrowing overflow is reported on st_ovf but the store proceeds.
module store_narrow_rmw
  import store_narrow_rmw_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  input  logic              st_signed,
  output logic              st_done,
  output logic              st_err,
  output logic              st_ovf,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned      TO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         data_q,  data_d;
  size_e               size_q,  size_d;
  logic [1:0]          off_q,   off_d;
  logic                sgn_q,   sgn_d;
  logic [TO_W-1:0]     cnt_q,   cnt_d;

  logic [31:0]         merged;
  logic                ovf;
  size_e               req_size;

  assign req_size = size_e'(st_size);

  store_lane_merge #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_merge (
    .old_word  (mem_rdata),
    .data      (data_q),
    .size      (size_q),
    .lane      (off_q),
    .is_signed (sgn_q),
    .merged    (merged),
    .ovf       (ovf)
  );

  // Next-state logic: decode at accept, then sequence read/write with a
  // per-access ack timeout. The merged word is captured on the read ack so
  // the write phase always starts in a later cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    size_d  = size_q;
    off_d   = off_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (st_valid) begin
          data_d = st_data;
          size_d = req_size;
          off_d  = st_addr[1:0];
          sgn_d  = st_signed;
          if (is_bad_access(req_size, st_addr[1:0])) begin
            state_d = ST_ERR_DONE;
          end else begin
            addr_d = {st_addr[ADDR_W-1:2], 2'b00};
            cnt_d  = '0;
            if (req_size == SZ_WORD) begin
              wdata_d = st_data;
              state_d = ST_WRITE;
            end else begin
              state_d = ST_READ;
            end
          end
        end
      end
      ST_READ: begin
        if (mem_ack) begin
          wdata_d = merged;
          cnt_d   = '0;
          state_d = ST_WRITE;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_ERR_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_ERR_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE:     state_d = ST_IDLE;
      ST_ERR_DONE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      size_q  <= SZ_BYTE;
      off_q   <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      size_q  <= size_d;
      off_q   <= off_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake and memory strobes are pure decodes of the current state.
  always_comb begin
    st_ready = (state_q == ST_IDLE);
    mem_req  = (state_q == ST_READ) || (state_q == ST_WRITE);
    mem_we   = (state_q == ST_WRITE);
    st_done  = (state_q == ST_DONE) || (state_q == ST_ERR_DONE);
    st_err   = (state_q == ST_ERR_DONE);
    st_ovf   = st_done && ovf;
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench for store_narrow_rmw: expected completions are queued at
// issue time and checked when st_done fires; a second instance with a short
// timeout covers the ack-timeout abort.
module tb_store_narrow_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        st_valid, st_ready, st_signed, st_done, st_err, st_ovf;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_size;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        b_st_valid, b_st_ready, b_st_done, b_st_err, b_st_ovf;
  logic        b_mem_req, b_mem_we, b_mem_ack;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  always #5 clk = ~clk;

  store_narrow_rmw #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .st_signed(st_signed), .st_done(st_done), .st_err(st_err),
    .st_ovf(st_ovf), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  store_narrow_rmw #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(4)) u_to (
    .clk(clk), .rst_n(rst_n),
    .st_valid(b_st_valid), .st_ready(b_st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .st_signed(st_signed), .st_done(b_st_done), .st_err(b_st_err),
    .st_ovf(b_st_ovf), .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: acks after ack_delay waiting cycles, logs every write.
  int          ack_delay  = 0;
  bit          ack_en     = 1'b1;
  int          wait_cnt   = 0;
  int          wr_cnt     = 0;
  int          req_cycles = 0;
  logic [31:0] rd_word    = '0;
  logic [31:0] last_wdata = '0;
  logic [31:0] last_waddr = '0;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      req_cycles++;
      if (ack_en && wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_word;
        wait_cnt  = 0;
        if (mem_we) begin
          wr_cnt++;
          last_wdata = mem_wdata;
          last_waddr = mem_addr;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  typedef struct {
    string       tag;
    logic        err;
    logic        ovf;
    logic [31:0] wdata;
    logic [31:0] waddr;
    int          lat;
    int          t0;
    int          wr_base;
    int          rq_base;
  } exp_t;

  exp_t sb[$];
  int   done_cnt = 0;

  // Scoreboard: each completion is compared against the oldest issued store.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && st_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(st_done), 32'd0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_err"}, 32'(st_err), 32'(e.err));
        check({e.tag, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
        if (!e.err) begin
          check({e.tag, "_ovf"},    32'(st_ovf), 32'(e.ovf));
          check({e.tag, "_nwr"},    32'(wr_cnt - e.wr_base), 32'd1);
          check({e.tag, "_wdata"},  last_wdata, e.wdata);
          check({e.tag, "_waddr"},  last_waddr, e.waddr);
        end else begin
          check({e.tag, "_noreq"},  32'(req_cycles - e.rq_base), 32'd0);
        end
      end
    end
  end

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic sg, input logic err,
                       input logic ovf, input logic [31:0] wd, input int lat);
    exp_t e;
    int   start;
    int   n;
    start = done_cnt;
    @(negedge clk);
    check({tag, "_ready"}, 32'(st_ready), 32'd1);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_size   = sz;
    st_signed = sg;
    e.tag = tag; e.err = err; e.ovf = ovf; e.wdata = wd;
    e.waddr = {a[31:2], 2'b00}; e.lat = lat; e.t0 = cyc;
    e.wr_base = wr_cnt; e.rq_base = req_cycles;
    sb.push_back(e);
    @(negedge clk);
    st_valid = 1'b0;
    check({tag, "_busy"}, 32'(st_ready), 32'd0);
    n = 0;
    while (done_cnt == start && n < 60) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_completed"}, 32'(done_cnt != start), 32'd1);
  endtask

  initial begin
    int reqs;
    int wes;
    int seen;
    int err_seen;
    int lat_to;
    int wr_base;

    st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = 2'b00; st_signed = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    b_st_valid = 1'b0; b_mem_ack = 1'b0; b_mem_rdata = '0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready",    32'(st_ready),  32'd1);
    check("rst_done",     32'(st_done),   32'd0);
    check("rst_err",      32'(st_err),    32'd0);
    check("rst_ovf",      32'(st_ovf),    32'd0);
    check("rst_req",      32'(mem_req),   32'd0);
    check("rst_we",       32'(mem_we),    32'd0);
    check("rst_addr",     mem_addr,       32'd0);
    check("rst_wdata",    mem_wdata,      32'd0);
    check("rst_b_ready",  32'(b_st_ready), 32'd1);
    check("rst_b_req",    32'(b_mem_req), 32'd0);
    rst_n = 1'b1;

    ack_delay = 0;
    rd_word = 32'h1122_3344;
    issue("sb_lane3", 32'h1003, 32'h0000_00AB, 2'b00, 1'b0, 1'b0, 1'b0, 32'h1122_33AB, 3);
    rd_word = 32'hAAAA_BBBB;
    issue("sh_fit",   32'h2002, 32'hFFFF_8001, 2'b01, 1'b1, 1'b0, 1'b0, 32'hAAAA_8001, 3);
    issue("sh_ovf",   32'h2002, 32'h0001_8001, 2'b01, 1'b1, 1'b0, 1'b1, 32'hAAAA_8001, 3);
    issue("sw_mis",   32'h3001, 32'h1234_5678, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    issue("sz_ill",   32'h3000, 32'h1234_5678, 2'b11, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    issue("sh_mis",   32'h2001, 32'h0000_1234, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0, 1);
    ack_delay = 5;
    issue("sw_slow",  32'h4000, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 7);
    ack_delay = 0;
    rd_word = 32'h1122_3344;
    issue("sb_lane0", 32'h5000, 32'h0000_01FF, 2'b00, 1'b0, 1'b0, 1'b1, 32'hFF22_3344, 3);
    issue("sb_sovf",  32'h7001, 32'h0000_0080, 2'b00, 1'b1, 1'b0, 1'b1, 32'h1180_3344, 3);
    rd_word = 32'hAAAA_BBBB;
    issue("sh_lane0", 32'h6000, 32'hFFFF_FF80, 2'b01, 1'b1, 1'b0, 1'b0, 32'hFF80_BBBB, 3);
    ack_delay = 2;
    rd_word = 32'h1122_3344;
    issue("sb_slow",  32'h7002, 32'h0000_005A, 2'b00, 1'b0, 1'b0, 1'b0, 32'h1122_5A44, 7);
    ack_delay = 0;

    // Ack timeout on the short-timeout instance: no ack ever arrives.
    reqs = 0; wes = 0; seen = 0; err_seen = 0; lat_to = 0;
    @(negedge clk);
    b_st_valid = 1'b1; st_addr = 32'h8000; st_data = 32'h12; st_size = 2'b00; st_signed = 1'b0;
    @(negedge clk);
    b_st_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (b_mem_req) reqs++;
      if (b_mem_we)  wes++;
      if (b_st_done) begin
        seen = 1; err_seen = 32'(b_st_err); lat_to = i;
        break;
      end
      @(negedge clk);
    end
    check("to_done_seen", 32'(seen),     32'd1);
    check("to_err",       32'(err_seen), 32'd1);
    check("to_req_cycles", 32'(reqs),    32'd4);
    check("to_no_write",  32'(wes),      32'd0);
    check("to_done_cycle", 32'(lat_to),  32'd4);
    @(negedge clk);
    check("to_ready_after", 32'(b_st_ready), 32'd1);
    check("to_req_after",   32'(b_mem_req),  32'd0);

    // Reset while the main instance waits in its read phase.
    ack_en  = 1'b0;
    wr_base = wr_cnt;
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h9001; st_data = 32'h77; st_size = 2'b00; st_signed = 1'b0;
    @(negedge clk);
    st_valid = 1'b0;
    check("rr_req",  32'(mem_req), 32'd1);
    check("rr_read", 32'(mem_we),  32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rr_req_dropped", 32'(mem_req),  32'd0);
    check("rr_ready",       32'(st_ready), 32'd1);
    check("rr_done",        32'(st_done),  32'd0);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rr_no_write",   32'(wr_cnt - wr_base), 32'd0);
    check("rr_idle_req",   32'(mem_req), 32'd0);
    check("sb_drained",    32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
